// File: rtl/tick_sequencer.sv
// tick_sequencer: startable/stoppable prescaled tick schedule.
// A prescaler raises CE every DIV+1 cycles while running and advances an
// event count toward LIMIT, either wrapping (MODE=0) or stopping in DONE
// once the count reaches LIMIT (MODE=1).
// Optional build macro: TICK_SEQ_PAUSE_EN adds a PAUSE input. While PAUSE is
// high in RUN, the prescaler and count freeze.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | stopped; count held, no CE
// RUN    | prescaler advancing, CE on each prescaler wrap (BUSY=1)
// DONE   | one-shot reached LIMIT; count held at LIMIT (DONE=1)
module tick_sequencer #(
  parameter int PRESCALE_W = 22,
  parameter int COUNT_W    = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic                  STOP,
  input  logic                  MODE,
  input  logic [PRESCALE_W-1:0] DIV,
  input  logic [COUNT_W-1:0]    LIMIT,
`ifdef TICK_SEQ_PAUSE_EN
  input  logic                  PAUSE,
`endif
  output logic                  CE,
  output logic                  CLR,
  output logic [COUNT_W-1:0]    COUNT,
  output logic                  BUSY,
  output logic                  DONE
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [PRESCALE_W-1:0] div_q, div_d;
  logic [COUNT_W-1:0]    limit_q, limit_d;
  logic                  mode_q, mode_d;
  logic [COUNT_W-1:0]    count_d, count_inc;
  logic                  ce_d, clr_d;
  logic                  hold;

`ifdef TICK_SEQ_PAUSE_EN
  assign hold = PAUSE;
`else
  assign hold = 1'b0;
`endif

  assign count_inc = COUNT + COUNT_W'(1);
  assign BUSY      = (state_q == S_RUN);
  assign DONE      = (state_q == S_DONE);

  // State, prescaler, latched configuration and registered pulse outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      div_q   <= '0;
      limit_q <= '0;
      mode_q  <= 1'b0;
      COUNT   <= '0;
      CE      <= 1'b0;
      CLR     <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      div_q   <= div_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      COUNT   <= count_d;
      CE      <= ce_d;
      CLR     <= clr_d;
    end
  end

  // Next-state logic: STOP beats START, START beats a tick
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    div_d   = div_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    count_d = COUNT;
    ce_d    = 1'b0;
    clr_d   = 1'b0;
    if (STOP) begin
      state_d = S_IDLE;
    end else if (START) begin
      div_d   = DIV;
      limit_d = LIMIT;
      mode_d  = MODE;
      presc_d = '0;
      count_d = '0;
      clr_d   = 1'b1;
      state_d = S_RUN;
    end else if (state_q == S_RUN && !hold) begin
      if (mode_q && limit_q == '0) begin
        // one-shot to zero: finished before any tick is due
        state_d = S_DONE;
      end else if (presc_q == div_q) begin
        presc_d = '0;
        ce_d    = 1'b1;
        if (!mode_q) begin
          count_d = (COUNT == limit_q) ? '0 : count_inc;
        end else begin
          count_d = count_inc;
          if (count_inc == limit_q) state_d = S_DONE;
        end
      end else begin
        presc_d = presc_q + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tick_sequencer.sv
// Directed bench for tick_sequencer: reset, wrap, one-shot, priority, pause.
module tb_tick_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START, STOP, MODE;
  logic [21:0] DIV;
  logic [7:0]  LIMIT;
  logic        PAUSE;
  logic        CE, CLR, BUSY, DONE;
  logic [7:0]  COUNT;

  int vectors = 0;
  int miscompares = 0;
  int ce_seen;

  always #5 CLK = ~CLK;

  tick_sequencer #(.PRESCALE_W(22), .COUNT_W(8)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .START (START),
    .STOP  (STOP),
    .MODE  (MODE),
    .DIV   (DIV),
    .LIMIT (LIMIT),
`ifdef TICK_SEQ_PAUSE_EN
    .PAUSE (PAUSE),
`endif
    .CE    (CE),
    .CLR   (CLR),
    .COUNT (COUNT),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ce, input logic clr,
                         input logic [7:0] cnt, input logic busy, input logic done);
    chk({tag, ".ce"},    {31'd0, CE},    {31'd0, ce});
    chk({tag, ".clr"},   {31'd0, CLR},   {31'd0, clr});
    chk({tag, ".count"}, {24'd0, COUNT}, {24'd0, cnt});
    chk({tag, ".busy"},  {31'd0, BUSY},  {31'd0, busy});
    chk({tag, ".done"},  {31'd0, DONE},  {31'd0, done});
  endtask

  task automatic do_start(input logic m, input logic [21:0] d, input logic [7:0] l);
    MODE = m; DIV = d; LIMIT = l; START = 1'b1;
    tick(1);
    START = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; START = 1'b0; STOP = 1'b0; MODE = 1'b0;
    DIV = '0; LIMIT = '0; PAUSE = 1'b0;
    #3;
    chk_all("reset", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    tick(2);
    RESET = 1'b0;
    tick(1);
    chk_all("idle", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

    // wrap mode DIV=3 LIMIT=4; inputs changed after START must be ignored
    do_start(1'b0, 22'd3, 8'd4);
    chk_all("wrap.start", 1'b0, 1'b1, 8'd0, 1'b1, 1'b0);
    DIV = 22'd9; LIMIT = 8'd1; MODE = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      tick(1);
      chk($sformatf("wrap.ce%0d", i), {31'd0, CE}, {31'd0, (i % 4 == 0)});
      chk($sformatf("wrap.cnt%0d", i), {24'd0, COUNT}, 32'((i / 4) % 5));
      chk($sformatf("wrap.busy%0d", i), {31'd0, BUSY}, 32'd1);
      if (i == 1) chk("wrap.clr_low", {31'd0, CLR}, 32'd0);
    end

    // reset in the middle of RUN with COUNT=5
    do_start(1'b0, 22'd3, 8'd10);
    tick(22);
    chk("rst.pre_count", {24'd0, COUNT}, 32'd5);
    chk("rst.pre_busy", {31'd0, BUSY}, 32'd1);
    #2 RESET = 1'b1;
    #1;
    chk_all("rst.async", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    tick(3);
    chk_all("rst.held", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    RESET = 1'b0;
    tick(4);
    chk_all("rst.after", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

    // one-shot DIV=0 LIMIT=3
    do_start(1'b1, 22'd0, 8'd3);
    chk_all("os.start", 1'b0, 1'b1, 8'd0, 1'b1, 1'b0);
    tick(1); chk_all("os.t1", 1'b1, 1'b0, 8'd1, 1'b1, 1'b0);
    tick(1); chk_all("os.t2", 1'b1, 1'b0, 8'd2, 1'b1, 1'b0);
    tick(1); chk_all("os.t3", 1'b1, 1'b0, 8'd3, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk_all($sformatf("os.hold%0d", i), 1'b0, 1'b0, 8'd3, 1'b0, 1'b1);
    end
    STOP = 1'b1; tick(1); STOP = 1'b0;
    chk_all("os.stop", 1'b0, 1'b0, 8'd3, 1'b0, 1'b0);

    // START and STOP together in RUN: STOP wins
    do_start(1'b0, 22'd3, 8'd10);
    tick(6);
    chk("prio.pre_count", {24'd0, COUNT}, 32'd1);
    START = 1'b1; STOP = 1'b1; tick(1); START = 1'b0; STOP = 1'b0;
    chk_all("prio.both", 1'b0, 1'b0, 8'd1, 1'b0, 1'b0);
    // STOP on the cycle a tick would fire
    do_start(1'b0, 22'd3, 8'd10);
    tick(3);
    STOP = 1'b1; tick(1); STOP = 1'b0;
    chk_all("prio.stop_ce", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    ce_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (CE) ce_seen++;
    end
    chk("prio.idle_noce", 32'(ce_seen), 32'd0);

    // one-shot LIMIT=0, then restart from DONE with LIMIT=2
    do_start(1'b1, 22'd2, 8'd0);
    chk_all("os0.start", 1'b0, 1'b1, 8'd0, 1'b1, 1'b0);
    tick(1);
    chk_all("os0.done", 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    ce_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (CE) ce_seen++;
    end
    chk("os0.noce", 32'(ce_seen), 32'd0);
    do_start(1'b1, 22'd1, 8'd2);
    chk_all("os2.start", 1'b0, 1'b1, 8'd0, 1'b1, 1'b0);
    tick(1); chk_all("os2.e1", 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    tick(1); chk_all("os2.e2", 1'b1, 1'b0, 8'd1, 1'b1, 1'b0);
    tick(1); chk_all("os2.e3", 1'b0, 1'b0, 8'd1, 1'b1, 1'b0);
    tick(1); chk_all("os2.e4", 1'b1, 1'b0, 8'd2, 1'b0, 1'b1);

    // LIMIT=255 wrap is natural 8-bit rollover
    do_start(1'b0, 22'd0, 8'd255);
    tick(255);
    chk_all("roll.255", 1'b1, 1'b0, 8'd255, 1'b1, 1'b0);
    tick(1);
    chk_all("roll.0", 1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
    STOP = 1'b1; tick(1); STOP = 1'b0;

`ifdef TICK_SEQ_PAUSE_EN
    // pause 10 cycles with prescaler at 5 (DIV=7)
    do_start(1'b0, 22'd7, 8'd10);
    tick(5);
    PAUSE = 1'b1;
    ce_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (CE) ce_seen++;
    end
    chk("pause.noce", 32'(ce_seen), 32'd0);
    chk_all("pause.held", 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    PAUSE = 1'b0;
    tick(1); chk("pause.r1", {31'd0, CE}, 32'd0);
    tick(1); chk("pause.r2", {31'd0, CE}, 32'd0);
    tick(1); chk_all("pause.r3", 1'b1, 1'b0, 8'd1, 1'b1, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
